// File: rtl/sf_fifo_pkg.sv
// Shared types and EOP encodings for the store-and-forward FIFO packet bookkeeping.
package sf_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IN_PKT,
    DISCARD
  } pkt_state_e;

  localparam int EOP_INBAND   = 0;
  localparam int EOP_SIDEBAND = 1;

endpackage

// File: rtl/sf_eop_detect.sv
// Combinational end-of-packet / error decode, in-band marker or sideband.
// Zero latency; no flow control of its own.
module sf_eop_detect
  import sf_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int EOP_MODE   = EOP_INBAND
) (
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wr_eop_i,
  input  logic                  wr_err_i,
  output logic                  eop_o,
  output logic                  err_o
);

  logic inband_eop;

  // In-band marker: all bits above bit 0 clear; bit 0 carries the error flag.
  assign inband_eop = (wdata_i[DATA_WIDTH-1:1] == '0);

  assign eop_o = (EOP_MODE == EOP_SIDEBAND) ? wr_eop_i : inband_eop;
  assign err_o = (EOP_MODE == EOP_SIDEBAND) ? wr_err_i : wdata_i[0];

endmodule

// File: rtl/sf_pkt_tracker.sv
// Packet bookkeeping for the store-and-forward FIFO: commit/drop at EOP (+1 cycle), resident count (+2).
// Write back-pressure only at packet boundaries, when committed plus pending packets fill capacity.
module sf_pkt_tracker
  import sf_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int EOP_MODE    = EOP_INBAND,
  parameter int MAX_PKT_LEN = 256,
  parameter int PKT_CNT_LG2 = 4,
  localparam int LEN_W      = $clog2(MAX_PKT_LEN + 1),
  localparam int CNT_W      = PKT_CNT_LG2 + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wr_eop_i,
  input  logic                  wr_err_i,
  output logic                  wr_ready_o,
  input  logic                  rd_pop_i,
  input  logic                  rd_eop_i,
  output logic                  eop_o,
  output logic [LEN_W-1:0]      wr_len_o,
  output logic                  commit_o,
  output logic                  drop_o,
  output logic                  pkt_avail_o,
  output logic [CNT_W-1:0]      pkt_cnt_o
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);
  localparam logic [CNT_W:0]   CAP     = (CNT_W + 1)'(1) << PKT_CNT_LG2;

  pkt_state_e       state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_inc;
  logic             commit_q;
  logic             drop_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   occupancy;
  logic             eop_raw;
  logic             err;
  logic             accepted;
  logic             pop_eop;

  sf_eop_detect #(
    .DATA_WIDTH (DATA_WIDTH),
    .EOP_MODE   (EOP_MODE)
  ) u_eop_detect (
    .wdata_i  (wdata_i),
    .wr_eop_i (wr_eop_i),
    .wr_err_i (wr_err_i),
    .eop_o    (eop_raw),
    .err_o    (err)
  );

  // The pending commit is counted so the counter cannot overflow one cycle later.
  assign occupancy  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, commit_q};
  assign wr_ready_o = !((state_q == IDLE) && (occupancy == CAP));
  assign accepted   = wr_valid_i & wr_ready_o;
  assign eop_o      = accepted & eop_raw;
  assign len_inc    = len_q + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      commit_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      drop_q   <= 1'b0;
      if (accepted) begin
        unique case (state_q)
          IDLE: begin
            if (eop_raw) begin
              commit_q <= ~err;
              drop_q   <= err;
              len_q    <= '0;
            end else begin
              state_q <= IN_PKT;
              len_q   <= LEN_W'(1);
            end
          end
          IN_PKT: begin
            if (eop_raw) begin
              commit_q <= ~err;
              drop_q   <= err;
              state_q  <= IDLE;
              len_q    <= '0;
            end else begin
              len_q <= len_inc;
              if (len_inc == MAX_LEN) state_q <= DISCARD;
            end
          end
          DISCARD: begin
            // Length stays saturated at MAX_LEN until the EOP closes the packet.
            if (eop_raw) begin
              drop_q  <= 1'b1;
              state_q <= IDLE;
              len_q   <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
            len_q   <= '0;
          end
        endcase
      end
    end
  end

  assign pop_eop = rd_pop_i & rd_eop_i;

  always_comb begin
    cnt_d = cnt_q;
    if (commit_q && !pop_eop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!commit_q && pop_eop && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wr_len_o    = len_q;
  assign commit_o    = commit_q;
  assign drop_o      = drop_q;
  assign pkt_cnt_o   = cnt_q;
  assign pkt_avail_o = (cnt_q != '0);

endmodule

// File: tb/tb_sf_pkt_tracker.sv
// Directed bench: in-band tracker (MAX_PKT_LEN=4, PKT_CNT_LG2=2) and a sideband tracker.
module tb_sf_pkt_tracker;
  import sf_fifo_pkg::*;

  logic clk;
  logic rst;

  // Instance A: in-band EOP, short max length, 4-packet capacity
  logic        a_valid, a_ready, a_pop, a_rdeop, a_eop_in, a_err_in;
  logic [31:0] a_wdata;
  logic        a_eop, a_commit, a_drop, a_avail;
  logic [2:0]  a_len;
  logic [2:0]  a_cnt;

  // Instance B: sideband EOP, default sizes
  logic        b_valid, b_ready, b_pop, b_rdeop, b_eop_in, b_err_in;
  logic [31:0] b_wdata;
  logic        b_eop, b_commit, b_drop, b_avail;
  logic [8:0]  b_len;
  logic [4:0]  b_cnt;

  int tests;
  int fails;

  sf_pkt_tracker #(
    .DATA_WIDTH  (32),
    .EOP_MODE    (EOP_INBAND),
    .MAX_PKT_LEN (4),
    .PKT_CNT_LG2 (2)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .wr_valid_i  (a_valid),
    .wdata_i     (a_wdata),
    .wr_eop_i    (a_eop_in),
    .wr_err_i    (a_err_in),
    .wr_ready_o  (a_ready),
    .rd_pop_i    (a_pop),
    .rd_eop_i    (a_rdeop),
    .eop_o       (a_eop),
    .wr_len_o    (a_len),
    .commit_o    (a_commit),
    .drop_o      (a_drop),
    .pkt_avail_o (a_avail),
    .pkt_cnt_o   (a_cnt)
  );

  sf_pkt_tracker #(
    .DATA_WIDTH  (32),
    .EOP_MODE    (EOP_SIDEBAND),
    .MAX_PKT_LEN (256),
    .PKT_CNT_LG2 (4)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .wr_valid_i  (b_valid),
    .wdata_i     (b_wdata),
    .wr_eop_i    (b_eop_in),
    .wr_err_i    (b_err_in),
    .wr_ready_o  (b_ready),
    .rd_pop_i    (b_pop),
    .rd_eop_i    (b_rdeop),
    .eop_o       (b_eop),
    .wr_len_o    (b_len),
    .commit_o    (b_commit),
    .drop_o      (b_drop),
    .pkt_avail_o (b_avail),
    .pkt_cnt_o   (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    a_valid = 0; a_wdata = '0; a_eop_in = 0; a_err_in = 0; a_pop = 0; a_rdeop = 0;
    b_valid = 0; b_wdata = '0; b_eop_in = 0; b_err_in = 0; b_pop = 0; b_rdeop = 0;
    #1;
    chk("rst_len",    32'(a_len),    0);
    chk("rst_commit", 32'(a_commit), 0);
    chk("rst_drop",   32'(a_drop),   0);
    chk("rst_cnt",    32'(a_cnt),    0);
    chk("rst_avail",  32'(a_avail),  0);
    chk("rst_ready",  32'(a_ready),  1);
    tick();
    tick();
    rst = 1'b0;

    // 3-word good packet
    a_valid = 1; a_wdata = 32'h10;
    #1 chk("t1_eop_w1", 32'(a_eop), 0);
    tick();
    chk("t1_len1", 32'(a_len), 1);
    a_wdata = 32'h20;
    tick();
    chk("t1_len2", 32'(a_len), 2);
    a_wdata = 32'h0;
    #1 chk("t1_eop_w3", 32'(a_eop), 1);
    tick();
    chk("t1_commit", 32'(a_commit), 1);
    chk("t1_drop",   32'(a_drop),   0);
    chk("t1_len0",   32'(a_len),    0);
    chk("t1_cnt_n1", 32'(a_cnt),    0);
    a_valid = 0;
    tick();
    chk("t1_commit_end", 32'(a_commit), 0);
    chk("t1_cnt",        32'(a_cnt),    1);
    chk("t1_avail",      32'(a_avail),  1);

    // 3-word packet ending in the error marker
    a_valid = 1; a_wdata = 32'h30;
    tick();
    a_wdata = 32'h40;
    tick();
    a_wdata = 32'h1;
    tick();
    chk("t2_drop",   32'(a_drop),   1);
    chk("t2_commit", 32'(a_commit), 0);
    a_valid = 0;
    tick();
    chk("t2_drop_end", 32'(a_drop), 0);
    chk("t2_cnt",      32'(a_cnt),  1);

    // Overlength: 6 words then EOP with MAX_PKT_LEN=4
    a_valid = 1; a_wdata = 32'h5;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) chk("t3_len3", 32'(a_len), 3);
      if (i == 4) chk("t3_len4", 32'(a_len), 4);
      if (i == 6) chk("t3_len_sat", 32'(a_len), 4);
      chk("t3_no_pulse", 32'({a_commit, a_drop}), 0);
    end
    a_wdata = 32'h0;
    #1 chk("t3_eop", 32'(a_eop), 1);
    tick();
    chk("t3_drop",   32'(a_drop),   1);
    chk("t3_commit", 32'(a_commit), 0);
    chk("t3_len0",   32'(a_len),    0);
    a_valid = 0;
    tick();
    chk("t3_drop_end", 32'(a_drop), 0);
    chk("t3_cnt",      32'(a_cnt),  1);

    // Commit coinciding with a read EOP at count 2
    a_valid = 1; a_wdata = 32'h0;
    tick();
    a_valid = 0;
    tick();
    chk("t5_cnt2", 32'(a_cnt), 2);
    a_valid = 1;
    tick();
    chk("t5_commit", 32'(a_commit), 1);
    a_valid = 0; a_pop = 1; a_rdeop = 1;
    tick();
    a_pop = 0; a_rdeop = 0;
    chk("t5_cnt_same", 32'(a_cnt), 2);
    tick();
    chk("t5_cnt_hold", 32'(a_cnt), 2);

    // Fill to capacity (4) with one-word packets
    a_valid = 1; a_wdata = 32'h0;
    tick();
    chk("t4_ready_occ3", 32'(a_ready), 1);
    tick();
    chk("t4_ready_full", 32'(a_ready), 0);
    #1 chk("t4_eop_blocked", 32'(a_eop), 0);
    tick();
    chk("t4_cnt4",   32'(a_cnt),    4);
    chk("t4_ready0", 32'(a_ready),  0);
    tick();
    chk("t4_no_commit", 32'(a_commit), 0);
    chk("t4_cnt_still", 32'(a_cnt),    4);
    a_valid = 0;
    a_pop = 1; a_rdeop = 0;
    tick();
    chk("t4_pop_noeop", 32'(a_cnt), 4);
    a_rdeop = 1;
    #1 chk("t4_ready_pre", 32'(a_ready), 0);
    tick();
    a_pop = 0; a_rdeop = 0;
    chk("t4_cnt3",   32'(a_cnt),   3);
    chk("t4_ready1", 32'(a_ready), 1);

    // Reset mid-packet at len 3
    a_valid = 1; a_wdata = 32'h11;
    tick();
    a_wdata = 32'h22;
    tick();
    a_wdata = 32'h33;
    tick();
    chk("t6_len3", 32'(a_len), 3);
    a_valid = 0;
    rst = 1'b1;
    #1;
    chk("t6_len",    32'(a_len),    0);
    chk("t6_cnt",    32'(a_cnt),    0);
    chk("t6_avail",  32'(a_avail),  0);
    chk("t6_ready",  32'(a_ready),  1);
    chk("t6_pulses", 32'({a_commit, a_drop}), 0);
    tick();
    rst = 1'b0;
    a_valid = 1; a_wdata = 32'hA;
    tick();
    chk("t6_len1", 32'(a_len), 1);
    a_wdata = 32'hB;
    tick();
    chk("t6_len2", 32'(a_len), 2);
    a_wdata = 32'h0;
    tick();
    chk("t6_commit", 32'(a_commit), 1);
    a_valid = 0;
    tick();
    chk("t6_cnt1", 32'(a_cnt), 1);

    // Sideband mode: data is never decoded
    b_valid = 1; b_wdata = 32'h0; b_eop_in = 0;
    #1 chk("t7_zero_not_eop", 32'(b_eop), 0);
    tick();
    chk("t7_len1", 32'(b_len), 1);
    b_wdata = 32'hFFFF_FFFF; b_eop_in = 1; b_err_in = 0;
    #1 chk("t7_eop", 32'(b_eop), 1);
    tick();
    chk("t7_commit", 32'(b_commit), 1);
    chk("t7_drop",   32'(b_drop),   0);
    chk("t7_len0",   32'(b_len),    0);
    b_wdata = 32'h0; b_err_in = 1;
    tick();
    chk("t7_err_drop",   32'(b_drop),   1);
    chk("t7_err_commit", 32'(b_commit), 0);
    b_valid = 0; b_eop_in = 0; b_err_in = 0;
    tick();
    chk("t7_cnt",   32'(b_cnt),   1);
    chk("t7_avail", 32'(b_avail), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
